pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage core.
- Generates stall/bubble for the PC register and the IFID, IDEX, EXMEM and MEMWB pipe registers.
- Handles load-use hazards, EX-resolved branch redirects, instruction/data memory wait states, and a multi-cycle MUL/DIV occupancy sequencer.
- The only block that drives pipe-register stall/bubble controls.

Parameters:
MD_CYCLES, 32, total EX occupancy of a MUL/DIV op in cycles including the start cycle; legal range >=2
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
rs1_id  in  5  ID-stage source register 1
rs2_id  in  5  ID-stage source register 2
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rd_ex  in  5  EX-stage destination register
mem_read_ex  in  1  EX instruction is a load
br_taken_ex  in  1  EX resolved a taken branch/jump (redirect)
md_start_ex  in  1  EX holds a MUL/DIV op; held high while it occupies EX
imem_wait  in  1  instruction memory not ready this cycle
dmem_wait  in  1  data memory (MEM stage) not ready this cycle
pc_stall  out  1  hold PC
ifid_stall, ifid_bubble  out  1 each  IFID controls
idex_stall, idex_bubble  out  1 each  IDEX controls
exmem_stall, exmem_bubble  out  1 each  EXMEM controls
memwb_stall, memwb_bubble  out  1 each  MEMWB controls
md_busy  out  1  MUL/DIV sequencer occupying EX
md_done  out  1  one-cycle pulse: MUL/DIV result valid in EX this cycle
stall_cycles  out  CNT_W  perf counter (optional feature)
flush_count  out  CNT_W  perf counter (optional feature)

Behaviour:
- Registered state: fsm {RUN, MD_BUSY}, down-counter md_cnt (clog2(MD_CYCLES) bits), perf counters. All control outputs are combinational from state and inputs, with zero latency.
- Reset (async): fsm=RUN, md_cnt=0, counters=0. With inputs idle, all outputs are 0. Reset mid-MUL/DIV returns to RUN and abandons the op.
- Invariant: stall and bubble are never both high on the same register.
- Priority, highest first:
  1. dmem_wait: pc, ifid, idex, exmem stall; memwb_bubble. fsm and md_cnt frozen. All lower rules are masked.
  2. RUN and md_start_ex: pc, ifid, idex stall; exmem_bubble; md_busy=1; load md_cnt=MD_CYCLES-1; next state MD_BUSY.
  3. MD_BUSY:
     - md_cnt>1: same stalls as rule 2; md_cnt decrements.
     - md_cnt==1: md_done=1, md_busy=1, no MD stalls (the pipeline advances); next state RUN.
     - md_start_ex is ignored throughout MD_BUSY.
  4. br_taken_ex: ifid_bubble, idex_bubble; PC not stalled (loads target). Load-use and imem_wait are ignored this cycle. br_taken_ex together with rule 2 cannot occur; MD wins regardless.
  5. Load-use: mem_read_ex && rd_ex!=0 && ((rs1_used_id && rs1_id==rd_ex) || (rs2_used_id && rs2_id==rd_ex)) gives pc_stall, ifid_stall, idex_bubble.
  6. imem_wait: pc_stall, ifid_bubble. When combined with load-use, ifid_stall overrides ifid_bubble.
- rd_ex==0 never triggers load-use.
- MD_CYCLES=2: a single stalled start cycle, then the done cycle.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: stall_cycles increments every cycle pc_stall=1; flush_count increments every cycle rule 4 fires. Both wrap modulo 2^CNT_W and clear on rst.
- Undefined: no counter registers; both ports driven constant 0.

Test Plan:
- Reset: rst=1 with md_start_ex=1 and dmem_wait=1. All control outputs follow the rules combinationally. After rst falls, fsm=RUN and, with inputs idle, every output is 0.
- Load-use: mem_read_ex=1, rd_ex=5, rs2_id=5, rs2_used_id=1 -> pc_stall=ifid_stall=idex_bubble=1, others 0. Repeat with rd_ex=0 -> all 0.
- MUL/DIV, MD_CYCLES=4, md_start_ex held: cycles 0-2 pc/ifid/idex stall=1, exmem_bubble=1. Cycle 3 md_done=1, no stalls. Cycle 4 md_busy=0.
- dmem_wait=1 for 2 cycles in the middle of the MD sequence above: md_cnt frozen, memwb_bubble=1, md_done is delayed exactly 2 cycles.
- br_taken_ex=1 with a simultaneous load-use match and imem_wait=1 -> ifid_bubble=idex_bubble=1, pc_stall=0, ifid_stall=0.
- PIPE_PERF_CNT_EN: 3 load-use cycles plus 1 branch -> stall_cycles=3, flush_count=1. With CNT_W=4 and 17 stall cycles -> stall_cycles=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Hazard-detection inputs and pipe-register control outputs exchanged between
// the 5-stage datapath and pipe_hazard_ctrl.
//   master : datapath side   (drives hazard info, receives stall/bubble)
//   slave  : controller side (receives hazard info, drives stall/bubble)
// Hazard info : rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
//               br_taken_ex, md_start_ex, imem_wait, dmem_wait
// Controls    : pc_stall, {ifid,idex,exmem,memwb}_{stall,bubble},
//               md_busy, md_done
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       rs1_used_id;
    logic       rs2_used_id;
    logic [4:0] rd_ex;
    logic       mem_read_ex;
    logic       br_taken_ex;
    logic       md_start_ex;
    logic       imem_wait;
    logic       dmem_wait;

    logic       pc_stall;
    logic       ifid_stall;
    logic       ifid_bubble;
    logic       idex_stall;
    logic       idex_bubble;
    logic       exmem_stall;
    logic       exmem_bubble;
    logic       memwb_stall;
    logic       memwb_bubble;
    logic       md_busy;
    logic       md_done;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
               br_taken_ex, md_start_ex, imem_wait, dmem_wait,
        input  pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble,
               exmem_stall, exmem_bubble, memwb_stall, memwb_bubble,
               md_busy, md_done
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
               br_taken_ex, md_start_ex, imem_wait, dmem_wait,
        output pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble,
               exmem_stall, exmem_bubble, memwb_stall, memwb_bubble,
               md_busy, md_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/bubble controller for the 5-stage core. Resolves, in priority
// order: data-memory wait, MUL/DIV EX occupancy, EX branch redirect,
// load-use hazard, instruction-memory wait. All controls are combinational
// from the current state and inputs; the only state is the MUL/DIV sequencer
// (RUN / MD_BUSY plus a down-counter) and the optional perf counters.
//
// Ports:
//   clk, rst      : core clock (rising edge), asynchronous active-high reset
//   hz (slave)    : hazard inputs in, pipe-register controls out
//   stall_cycles  : cycles with pc_stall=1         (perf counter)
//   flush_count   : cycles a branch redirect fired (perf counter)
//
// Build option: define PIPE_PERF_CNT_EN to implement the perf counters;
// without it both counter ports are tied to 0.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int MDC_W = $clog2(MD_CYCLES);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t           state, state_nxt;
    logic [MDC_W-1:0] md_cnt, md_cnt_nxt;

    logic load_use;
    logic md_hold;
    logic pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble;
    logic exmem_stall, exmem_bubble, memwb_stall, memwb_bubble;
    logic md_busy, md_done;

    // x0 is hardwired zero, so a load targeting it never creates a hazard.
    always_comb begin
        load_use = hz.mem_read_ex && (hz.rd_ex != 5'd0) &&
                   ((hz.rs1_used_id && (hz.rs1_id == hz.rd_ex)) ||
                    (hz.rs2_used_id && (hz.rs2_id == hz.rd_ex)));
    end

    always_comb begin
        state_nxt    = state;
        md_cnt_nxt   = md_cnt;
        md_hold      = 1'b0;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_bubble  = 1'b0;
        idex_stall   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_stall  = 1'b0;
        exmem_bubble = 1'b0;
        memwb_stall  = 1'b0;
        memwb_bubble = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;

        if (hz.dmem_wait) begin
            // Freeze everything up to MEM; sequencer state holds via defaults.
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
        end else begin
            if (state == RUN && hz.md_start_ex) begin
                md_hold    = 1'b1;
                md_cnt_nxt = MDC_W'(MD_CYCLES - 1);
                state_nxt  = MD_BUSY;
            end else if (state == MD_BUSY) begin
                if (md_cnt > MDC_W'(1)) begin
                    md_hold    = 1'b1;
                    md_cnt_nxt = md_cnt - MDC_W'(1);
                end else begin
                    // Result cycle: op leaves EX, so lower rules may act.
                    md_done    = 1'b1;
                    md_busy    = 1'b1;
                    md_cnt_nxt = '0;
                    state_nxt  = RUN;
                end
            end

            if (md_hold) begin
                pc_stall     = 1'b1;
                ifid_stall   = 1'b1;
                idex_stall   = 1'b1;
                exmem_bubble = 1'b1;
                md_busy      = 1'b1;
            end else if (hz.br_taken_ex) begin
                // Squash the two wrong-path instructions; PC takes the target.
                ifid_bubble = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                // Also covers imem_wait: holding IFID keeps the fetched instr.
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end else if (hz.imem_wait) begin
                pc_stall    = 1'b1;
                ifid_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    assign hz.pc_stall     = pc_stall;
    assign hz.ifid_stall   = ifid_stall;
    assign hz.ifid_bubble  = ifid_bubble;
    assign hz.idex_stall   = idex_stall;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.exmem_stall  = exmem_stall;
    assign hz.exmem_bubble = exmem_bubble;
    assign hz.memwb_stall  = memwb_stall;
    assign hz.memwb_bubble = memwb_bubble;
    assign hz.md_busy      = md_busy;
    assign hz.md_done      = md_done;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Only a branch redirect bubbles IFID and IDEX together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_stall)
                stall_q <= stall_q + CNT_W'(1);
            if (ifid_bubble && idex_bubble)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    localparam int MDC = 4;
    localparam int CW  = 4;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // control vector: {pc_s, ifid_s, ifid_b, idex_s, idex_b, exmem_s, exmem_b,
    //                  memwb_s, memwb_b, md_busy, md_done}
    localparam logic [10:0] L_PC  = 11'b100_0000_0000;
    localparam logic [10:0] L_IFS = 11'b010_0000_0000;
    localparam logic [10:0] L_IFB = 11'b001_0000_0000;
    localparam logic [10:0] L_IDS = 11'b000_1000_0000;
    localparam logic [10:0] L_IDB = 11'b000_0100_0000;
    localparam logic [10:0] L_EXS = 11'b000_0010_0000;
    localparam logic [10:0] L_EXB = 11'b000_0001_0000;
    localparam logic [10:0] L_MWB = 11'b000_0000_0100;
    localparam logic [10:0] L_BSY = 11'b000_0000_0010;
    localparam logic [10:0] L_DON = 11'b000_0000_0001;

    localparam logic [10:0] E_NONE = 11'b0;
    localparam logic [10:0] E_DMEM = L_PC | L_IFS | L_IDS | L_EXS | L_MWB;
    localparam logic [10:0] E_MD   = L_PC | L_IFS | L_IDS | L_EXB | L_BSY;
    localparam logic [10:0] E_DONE = L_BSY | L_DON;
    localparam logic [10:0] E_LU   = L_PC | L_IFS | L_IDB;
    localparam logic [10:0] E_BR   = L_IFB | L_IDB;
    localparam logic [10:0] E_IMEM = L_PC | L_IFB;

    typedef struct {
        string       nm;
        logic [10:0] ctl;
        bit          cc;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] sc_o, fc_o;
    item_t q[$];
    item_t it;
    int n_cmp = 0;
    int n_bad = 0;
    logic [10:0] got;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.MD_CYCLES(MDC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .hz(hz),
        .stall_cycles(sc_o), .flush_count(fc_o)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic mr, input logic br, input logic md,
                          input logic iw, input logic dw);
        hz.rs1_id = r1; hz.rs2_id = r2; hz.rs1_used_id = u1; hz.rs2_used_id = u2;
        hz.rd_ex = rd; hz.mem_read_ex = mr; hz.br_taken_ex = br;
        hz.md_start_ex = md; hz.imem_wait = iw; hz.dmem_wait = dw;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Push the expectation for the current cycle, then advance one cycle.
    task automatic cyc(input string nm, input logic [10:0] e, input bit cc = 1'b0,
                       input int sc = 0, input int fc = 0);
        item_t x;
        x.nm = nm; x.ctl = e; x.cc = cc;
        x.sc = PERF ? CW'(sc) : '0;
        x.fc = PERF ? CW'(fc) : '0;
        q.push_back(x);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            it = q.pop_front();
            got = {hz.pc_stall, hz.ifid_stall, hz.ifid_bubble, hz.idex_stall,
                   hz.idex_bubble, hz.exmem_stall, hz.exmem_bubble,
                   hz.memwb_stall, hz.memwb_bubble, hz.md_busy, hz.md_done};
            n_cmp++;
            if (got !== it.ctl) begin
                n_bad++;
                $display("FAIL %s: ctl got %b want %b", it.nm, got, it.ctl);
            end
            if (it.cc) begin
                n_cmp++;
                if (sc_o !== it.sc || fc_o !== it.fc) begin
                    n_bad++;
                    $display("FAIL %s cnt: got sc=%0d fc=%0d want sc=%0d fc=%0d",
                             it.nm, sc_o, fc_o, it.sc, it.fc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        cyc("rst_dmem", E_DMEM);
        hz.dmem_wait = 1'b0;
        cyc("rst_md", E_MD);
        rst = 1'b0;
        idle();
        cyc("rst_idle", E_NONE, 1'b1, 0, 0);

        // Perf counters: 3 load-use + 1 branch, then wrap at 17 stalls.
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lu_rs2", E_LU);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("br", E_BR);
        idle();
        cyc("cnt_3_1", E_NONE, 1'b1, 3, 1);
        set_in(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) cyc("lu_rs1", E_LU);
        idle();
        cyc("cnt_wrap", E_NONE, 1'b1, 1, 1);

        // Load-use negatives.
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_rd0", E_NONE);
        set_in(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_unused", E_NONE);
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_noload", E_NONE);

        // Branch beats load-use and imem_wait.
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("br_lu_imem", E_BR);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("imem", E_IMEM);
        set_in(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("imem_lu", E_LU);
        set_in(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("dmem_all", E_DMEM);

        // MUL/DIV, 4 cycles.
        idle(); hz.md_start_ex = 1'b1;
        cyc("md_c0", E_MD);
        cyc("md_c1", E_MD);
        cyc("md_c2", E_MD);
        cyc("md_c3", E_DONE);
        hz.md_start_ex = 1'b0;
        cyc("md_c4", E_NONE);

        // MUL/DIV with 2 dmem_wait cycles in the middle.
        hz.md_start_ex = 1'b1;
        cyc("mdw_c0", E_MD);
        cyc("mdw_c1", E_MD);
        hz.dmem_wait = 1'b1;
        cyc("mdw_w0", E_DMEM);
        cyc("mdw_w1", E_DMEM);
        hz.dmem_wait = 1'b0;
        cyc("mdw_c2", E_MD);
        cyc("mdw_c3", E_DONE);
        hz.md_start_ex = 1'b0;
        cyc("mdw_c4", E_NONE);

        // Reset mid-MUL/DIV abandons the op.
        hz.md_start_ex = 1'b1;
        cyc("mdr_c0", E_MD);
        cyc("mdr_c1", E_MD);
        rst = 1'b1; hz.md_start_ex = 1'b0;
        cyc("mdr_rst", E_NONE, 1'b1, 0, 0);
        rst = 1'b0;
        cyc("mdr_idle", E_NONE);
        cyc("mdr_idle2", E_NONE);

        @(negedge clk); #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
